// File: rtl/int_ctrl_pkg.sv
// int_ctrl_pkg: cause codes and sequencer state encoding shared by int_ctrl.
package int_ctrl_pkg;

  localparam int unsigned CAUSE_SYS      = 8;
  localparam int unsigned CAUSE_OV       = 12;
  localparam int unsigned CAUSE_IRQ_BASE = 16;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ENTER   = 2'd1,
    ST_HANDLER = 2'd2,
    ST_RETURN  = 2'd3
  } state_e;

endpackage

// File: rtl/int_ctrl_irq_sync_edge.sv
// irq_sync_edge: two-flop synchroniser for one asynchronous interrupt line,
// followed by a rising-edge detector on the synchronised level.
//   clk, rst : clock, asynchronous active-high reset
//   din      : raw asynchronous level
//   rise_c   : one-cycle pulse when the synchronised level goes 0 -> 1
module irq_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic rise_c
);

  logic meta;
  logic sync;
  logic prev;

  // meta/sync form the synchroniser, prev holds last synchronised level
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= 1'b0;
      sync <= 1'b0;
      prev <= 1'b0;
    end else begin
      meta <= din;
      sync <= meta;
      prev <= sync;
    end
  end

  assign rise_c = sync & ~prev;

endmodule

// File: rtl/int_ctrl.sv
// int_ctrl: interrupt/exception sequencer in front of the CP0 register file.
// Latches synchronised interrupt edges, picks the highest-priority event at an
// instruction boundary and issues one-cycle EPC/Cause/Enable write strobes and
// a fetch redirect; on ERET re-enables interrupts and returns to EPC.
//   irq_i                   : raw asynchronous interrupt levels
//   syscall_i/ovf_i/eret_i  : committed events, qualified by inst_done_i
//   pc_next_i               : next PC, latched by CP0 itself on write_epc_o
//   int_en_i, base_i, epc_i : current CP0 Enable[0], Base and EPC
//   write_*_o, cause_o, int_en_o : registered CP0 write strobes and data
//   redirect_o, redirect_pc_o    : one-cycle fetch redirect
//   irq_ack_o               : one-hot acknowledge of the serviced line
//   nest_err_o              : sticky, exception raised inside the handler
module int_ctrl
  import int_ctrl_pkg::*;
#(
  parameter int unsigned NUM_IRQ = 8,
  parameter int unsigned CAUSE_W = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_IRQ-1:0] irq_i,
  input  logic               syscall_i,
  input  logic               ovf_i,
  input  logic               eret_i,
  input  logic               inst_done_i,
  input  logic [31:0]        pc_next_i,
  input  logic               int_en_i,
  input  logic [31:0]        base_i,
  input  logic [31:0]        epc_i,
  output logic               write_epc_o,
  output logic               write_cause_o,
  output logic [CAUSE_W-1:0] cause_o,
  output logic               write_int_o,
  output logic               int_en_o,
  output logic               redirect_o,
  output logic [31:0]        redirect_pc_o,
  output logic [NUM_IRQ-1:0] irq_ack_o,
  output logic               nest_err_o
);

  state_e             state;
  state_e             state_n;
  logic [NUM_IRQ-1:0] rise;
  logic [NUM_IRQ-1:0] pending;
  logic [NUM_IRQ-1:0] pending_n;
  logic [NUM_IRQ-1:0] irq_sel;
  logic [CAUSE_W-1:0] irq_code;
  logic               enter;
  logic               write_epc_n;
  logic               write_cause_n;
  logic [CAUSE_W-1:0] cause_n;
  logic               write_int_n;
  logic               int_en_n;
  logic               redirect_n;
  logic [31:0]        redirect_pc_n;
  logic [NUM_IRQ-1:0] irq_ack_n;
  logic               nest_err_n;

  // pc_next_i goes straight to CP0; it is listed here only for the contract
  logic unused_pc_next;
  assign unused_pc_next = ^pc_next_i;

  // One synchroniser + edge detector per line
  for (genvar k = 0; k < NUM_IRQ; k++) begin : g_sync
    irq_sync_edge u_sync (
      .clk    (clk),
      .rst    (rst),
      .din    (irq_i[k]),
      .rise_c (rise[k])
    );
  end

  // A new edge wins over a simultaneous acknowledge
  assign pending_n = (pending & ~irq_ack_o) | rise;

  // Priority encoder: lowest pending index wins
  always_comb begin
    irq_sel  = '0;
    irq_code = '0;
    for (int k = int'(NUM_IRQ) - 1; k >= 0; k--) begin
      if (pending[k]) begin
        irq_sel    = '0;
        irq_sel[k] = 1'b1;
        irq_code   = CAUSE_W'(CAUSE_IRQ_BASE + 32'(k));
      end
    end
  end

  // Next state and next registered outputs
  always_comb begin
    state_n       = state;
    enter         = 1'b0;
    write_epc_n   = 1'b0;
    write_cause_n = 1'b0;
    cause_n       = '0;
    write_int_n   = 1'b0;
    int_en_n      = 1'b0;
    redirect_n    = 1'b0;
    redirect_pc_n = '0;
    irq_ack_n     = '0;
    nest_err_n    = nest_err_o;

    case (state)
      ST_IDLE: begin
        if (inst_done_i && (syscall_i || ovf_i)) begin
          enter   = 1'b1;
          cause_n = syscall_i ? CAUSE_W'(CAUSE_SYS) : CAUSE_W'(CAUSE_OV);
        end else if (inst_done_i && int_en_i && (|pending)) begin
          enter     = 1'b1;
          cause_n   = irq_code;
          irq_ack_n = irq_sel;
        end
      end
      ST_ENTER: state_n = ST_HANDLER;
      ST_HANDLER: begin
        // Nested exceptions are flagged and otherwise dropped
        if (inst_done_i && (syscall_i || ovf_i)) begin
          nest_err_n = 1'b1;
        end
        if (inst_done_i && eret_i) begin
          state_n       = ST_RETURN;
          write_int_n   = 1'b1;
          int_en_n      = 1'b1;
          redirect_n    = 1'b1;
          redirect_pc_n = epc_i;
        end
      end
      ST_RETURN: state_n = ST_IDLE;
      default:   state_n = ST_IDLE;
    endcase

    if (enter) begin
      state_n       = ST_ENTER;
      write_epc_n   = 1'b1;
      write_cause_n = 1'b1;
      write_int_n   = 1'b1;
      int_en_n      = 1'b0;
      redirect_n    = 1'b1;
      redirect_pc_n = base_i;
    end
  end

  // State, pending set and registered strobes
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= ST_IDLE;
      pending       <= '0;
      write_epc_o   <= 1'b0;
      write_cause_o <= 1'b0;
      cause_o       <= '0;
      write_int_o   <= 1'b0;
      int_en_o      <= 1'b0;
      redirect_o    <= 1'b0;
      redirect_pc_o <= '0;
      irq_ack_o     <= '0;
      nest_err_o    <= 1'b0;
    end else begin
      state         <= state_n;
      pending       <= pending_n;
      write_epc_o   <= write_epc_n;
      write_cause_o <= write_cause_n;
      cause_o       <= cause_n;
      write_int_o   <= write_int_n;
      int_en_o      <= int_en_n;
      redirect_o    <= redirect_n;
      redirect_pc_o <= redirect_pc_n;
      irq_ack_o     <= irq_ack_n;
      nest_err_o    <= nest_err_n;
    end
  end

endmodule

// File: tb/tb_int_ctrl.sv
// tb_int_ctrl: directed scenarios plus a randomized run checked against an
// event-level reference model of the interrupt sequencer.
module tb_int_ctrl;

  localparam int unsigned NI = 8;
  localparam int unsigned CW = 5;

  localparam int PH_WAIT    = 0;
  localparam int PH_ENTERED = 1;
  localparam int PH_INHAND  = 2;
  localparam int PH_LEAVING = 3;

  logic          clk;
  logic          rst;
  logic [NI-1:0] irq;
  logic          syscall;
  logic          ovf;
  logic          eret;
  logic          inst_done;
  logic [31:0]   pc_next;
  logic          int_en;
  logic [31:0]   base;
  logic [31:0]   epc;
  logic          write_epc_o;
  logic          write_cause_o;
  logic [CW-1:0] cause_o;
  logic          write_int_o;
  logic          int_en_o;
  logic          redirect_o;
  logic [31:0]   redirect_pc_o;
  logic [NI-1:0] irq_ack_o;
  logic          nest_err_o;

  logic [50:0]   obs;
  assign obs = {nest_err_o, write_epc_o, write_cause_o, cause_o, write_int_o,
                int_en_o, redirect_o, redirect_pc_o, irq_ack_o};

  int errors = 0;
  int checks = 0;

  // Reference model state
  logic [NI-1:0] m_pend;
  logic [NI-1:0] h1, h2, h3;   // irq as sampled 1, 2 and 3 edges ago
  int            m_phase;
  logic          m_nest;
  logic [50:0]   m_exp;

  int_ctrl #(.NUM_IRQ(NI), .CAUSE_W(CW)) dut (
    .clk           (clk),
    .rst           (rst),
    .irq_i         (irq),
    .syscall_i     (syscall),
    .ovf_i         (ovf),
    .eret_i        (eret),
    .inst_done_i   (inst_done),
    .pc_next_i     (pc_next),
    .int_en_i      (int_en),
    .base_i        (base),
    .epc_i         (epc),
    .write_epc_o   (write_epc_o),
    .write_cause_o (write_cause_o),
    .cause_o       (cause_o),
    .write_int_o   (write_int_o),
    .int_en_o      (int_en_o),
    .redirect_o    (redirect_o),
    .redirect_pc_o (redirect_pc_o),
    .irq_ack_o     (irq_ack_o),
    .nest_err_o    (nest_err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  function automatic logic [50:0] enter_vec(input logic n, input logic [CW-1:0] c,
                                            input logic [31:0] pc, input logic [NI-1:0] a);
    return {n, 1'b1, 1'b1, c, 1'b1, 1'b0, 1'b1, pc, a};
  endfunction

  function automatic logic [50:0] return_vec(input logic n, input logic [31:0] pc);
    return {n, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b1, pc, 8'd0};
  endfunction

  function automatic logic [50:0] idle_vec(input logic n);
    return {n, 50'd0};
  endfunction

  function automatic int lowest(input logic [NI-1:0] p);
    for (int i = 0; i < int'(NI); i++) if (p[i]) return i;
    return 0;
  endfunction

  task automatic model_clear();
    m_pend  = '0;
    h1      = '0;
    h2      = '0;
    h3      = '0;
    m_phase = PH_WAIT;
    m_nest  = 1'b0;
    m_exp   = '0;
  endtask

  // One clock edge of the sequencer, described as events
  task automatic model_update();
    logic [NI-1:0] rise;
    logic [NI-1:0] pend_old;
    int            k;
    rise     = h2 & ~h3;
    h3       = h2;
    h2       = h1;
    h1       = irq;
    pend_old = m_pend;
    m_pend   = (m_pend & ~m_exp[NI-1:0]) | rise;
    if (m_phase == PH_WAIT) begin
      if (inst_done && (syscall || ovf)) begin
        m_phase = PH_ENTERED;
        m_exp   = enter_vec(m_nest, syscall ? 5'd8 : 5'd12, base, '0);
      end else if (inst_done && int_en && pend_old != '0) begin
        k       = lowest(pend_old);
        m_phase = PH_ENTERED;
        m_exp   = enter_vec(m_nest, 5'(16 + k), base, NI'(1) << k);
      end else begin
        m_exp = idle_vec(m_nest);
      end
    end else if (m_phase == PH_ENTERED) begin
      m_phase = PH_INHAND;
      m_exp   = idle_vec(m_nest);
    end else if (m_phase == PH_INHAND) begin
      if (inst_done && (syscall || ovf)) m_nest = 1'b1;
      if (inst_done && eret) begin
        m_phase = PH_LEAVING;
        m_exp   = return_vec(m_nest, epc);
      end else begin
        m_exp = idle_vec(m_nest);
      end
    end else begin
      m_phase = PH_WAIT;
      m_exp   = idle_vec(m_nest);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic wait_enter(input int max, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max && !ok; i++) begin
      tick();
      ok = (write_epc_o === 1'b1);
    end
  endtask

  task automatic handler_return(input logic [31:0] e);
    eret = 1'b1;
    epc  = e;
    tick();
    eret = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; irq = '0; syscall = 1'b0; ovf = 1'b0; eret = 1'b0;
    inst_done = 1'b0; pc_next = '0; int_en = 1'b0; base = '0; epc = '0;
    #1;
    checks++;
    if (obs !== '0) begin errors++; $display("FAIL reset_out got=%h want=0", obs); end
    model_clear();
    repeat (2) @(negedge clk);
    checks++;
    if (obs !== '0) begin errors++; $display("FAIL reset_held got=%h want=0", obs); end
    rst = 1'b0;
  endtask

  task automatic test_single_irq();
    bit ok;
    int_en = 1'b1; inst_done = 1'b1; pc_next = 32'h100; base = 32'h8000;
    irq[3] = 1'b1;
    wait_enter(10, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL irq3_timeout got=no_enter want=enter"); end
    checks++;
    if (obs !== enter_vec(1'b0, 5'd19, 32'h8000, 8'h08)) begin
      errors++; $display("FAIL irq3_enter got=%h want=%h", obs, enter_vec(1'b0, 5'd19, 32'h8000, 8'h08));
    end
    irq[3] = 1'b0;
    tick();
    checks++;
    if (obs !== idle_vec(1'b0)) begin errors++; $display("FAIL irq3_one_cycle got=%h want=%h", obs, idle_vec(1'b0)); end
    handler_return(32'h104);
    checks++;
    if (obs !== return_vec(1'b0, 32'h104)) begin
      errors++; $display("FAIL irq3_return got=%h want=%h", obs, return_vec(1'b0, 32'h104));
    end
    wait_enter(8, ok);
    checks++;
    if (ok) begin errors++; $display("FAIL irq3_retaken got=enter want=none"); end
  endtask

  task automatic test_two_irq();
    bit ok;
    irq = 8'h22;
    wait_enter(10, ok);
    checks++;
    if (obs !== enter_vec(1'b0, 5'd17, 32'h8000, 8'h02)) begin
      errors++; $display("FAIL two_first got=%h want=%h ok=%0b", obs, enter_vec(1'b0, 5'd17, 32'h8000, 8'h02), ok);
    end
    tick();
    handler_return(32'h104);
    checks++;
    if (obs !== return_vec(1'b0, 32'h104)) begin
      errors++; $display("FAIL two_return got=%h want=%h", obs, return_vec(1'b0, 32'h104));
    end
    wait_enter(4, ok);
    checks++;
    if (obs !== enter_vec(1'b0, 5'd21, 32'h8000, 8'h20)) begin
      errors++; $display("FAIL two_second got=%h want=%h ok=%0b", obs, enter_vec(1'b0, 5'd21, 32'h8000, 8'h20), ok);
    end
    irq = '0;
    tick();
    handler_return(32'h200);
  endtask

  task automatic test_sys_vs_irq();
    bit ok;
    int_en = 1'b0;
    irq[0] = 1'b1;
    repeat (5) tick();
    int_en  = 1'b1;
    syscall = 1'b1;
    tick();
    syscall = 1'b0;
    checks++;
    if (obs !== enter_vec(1'b0, 5'd8, 32'h8000, 8'h00)) begin
      errors++; $display("FAIL sys_first got=%h want=%h", obs, enter_vec(1'b0, 5'd8, 32'h8000, 8'h00));
    end
    tick();
    handler_return(32'h300);
    checks++;
    if (obs !== return_vec(1'b0, 32'h300)) begin
      errors++; $display("FAIL sys_return got=%h want=%h", obs, return_vec(1'b0, 32'h300));
    end
    wait_enter(4, ok);
    checks++;
    if (obs !== enter_vec(1'b0, 5'd16, 32'h8000, 8'h01)) begin
      errors++; $display("FAIL sys_irq0_kept got=%h want=%h ok=%0b", obs, enter_vec(1'b0, 5'd16, 32'h8000, 8'h01), ok);
    end
    irq[0] = 1'b0;
    tick();
    handler_return(32'h304);
  endtask

  task automatic test_int_en_gate();
    bit seen;
    seen   = 1'b0;
    int_en = 1'b0;
    irq[2] = 1'b1;
    repeat (20) begin
      tick();
      if (write_epc_o === 1'b1 || redirect_o === 1'b1) seen = 1'b1;
    end
    checks++;
    if (seen) begin errors++; $display("FAIL gate_blocked got=strobe want=none"); end
    int_en = 1'b1;
    tick();
    checks++;
    if (obs !== enter_vec(1'b0, 5'd18, 32'h8000, 8'h04)) begin
      errors++; $display("FAIL gate_release got=%h want=%h", obs, enter_vec(1'b0, 5'd18, 32'h8000, 8'h04));
    end
    irq[2] = 1'b0;
    tick();
    handler_return(32'h400);
  endtask

  task automatic test_nested();
    tick();
    ovf = 1'b1;
    tick();
    ovf = 1'b0;
    checks++;
    if (obs !== enter_vec(1'b0, 5'd12, 32'h8000, 8'h00)) begin
      errors++; $display("FAIL nest_ovf_enter got=%h want=%h", obs, enter_vec(1'b0, 5'd12, 32'h8000, 8'h00));
    end
    tick();
    ovf = 1'b1;
    tick();
    ovf = 1'b0;
    checks++;
    if (obs !== idle_vec(1'b1)) begin errors++; $display("FAIL nest_flag got=%h want=%h", obs, idle_vec(1'b1)); end
    repeat (3) tick();
    handler_return(32'h500);
    checks++;
    if (obs !== return_vec(1'b1, 32'h500)) begin
      errors++; $display("FAIL nest_sticky got=%h want=%h", obs, return_vec(1'b1, 32'h500));
    end
  endtask

  task automatic test_reset_mid_enter();
    bit ok;
    tick();
    int_en = 1'b0;
    irq    = 8'h50;
    repeat (5) tick();
    int_en = 1'b1;
    tick();
    checks++;
    if (obs !== enter_vec(1'b1, 5'd20, 32'h8000, 8'h10)) begin
      errors++; $display("FAIL rst_pre_enter got=%h want=%h", obs, enter_vec(1'b1, 5'd20, 32'h8000, 8'h10));
    end
    rst = 1'b1;
    irq = '0;
    #1;
    checks++;
    if (obs !== '0) begin errors++; $display("FAIL rst_abort got=%h want=0", obs); end
    model_clear();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    wait_enter(8, ok);
    checks++;
    if (ok) begin errors++; $display("FAIL rst_pending_cleared got=enter want=none"); end
    syscall = 1'b1;
    tick();
    syscall = 1'b0;
    checks++;
    if (obs !== enter_vec(1'b0, 5'd8, 32'h8000, 8'h00)) begin
      errors++; $display("FAIL rst_idle got=%h want=%h", obs, enter_vec(1'b0, 5'd8, 32'h8000, 8'h00));
    end
    tick();
    handler_return(32'h600);
  endtask

  task automatic test_random();
    rst = 1'b1;
    #1;
    model_clear();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 1500; i++) begin
      for (int b = 0; b < int'(NI); b++) if ($urandom_range(15) == 0) irq[b] = ~irq[b];
      inst_done = ($urandom_range(9) < 7);
      syscall   = ($urandom_range(29) == 0);
      ovf       = ($urandom_range(29) == 0);
      eret      = ($urandom_range(5) == 0);
      int_en    = ($urandom_range(9) != 0);
      pc_next   = $urandom;
      base      = $urandom;
      epc       = $urandom;
      tick();
      checks++;
      if (obs !== m_exp) begin
        errors++; $display("FAIL rand_cycle%0d got=%h want=%h", i, obs, m_exp);
      end
      if (i == 750) begin
        rst = 1'b1;
        #1;
        model_clear();
        checks++;
        if (obs !== '0) begin errors++; $display("FAIL rand_reset got=%h want=0", obs); end
        repeat (2) @(negedge clk);
        rst = 1'b0;
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_irq();
    test_two_irq();
    test_sys_vs_irq();
    test_int_en_gate();
    test_nested();
    test_reset_mid_enter();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
